// File: rtl/keypad_scanner.sv
// Matrix keypad reader: walks one active-low column at a time, debounces a
// single pressed key and reports its code with a one-cycle strobe.
module keypad_scanner #(
  parameter int CLK_DIV        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col_choice,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t           state_q, state_d;
  logic [3:0]       row_p0, row_p1;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] rel_q, rel_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       col_d, code_d;
  logic             valid_d, held_d;
  logic [3:0]       row_low, col_next;
  logic             none, single;
  logic [1:0]       row_idx, col_idx;

  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_p0 <= 4'hF;
      row_p1 <= 4'hF;
    end else begin
      row_p0 <= row;
      row_p1 <= row_p0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_cnt <= '0;
    else       div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
  end

  always_comb begin
    tick     = (div_cnt == DIV_LAST);
    row_low  = ~row_p1;
    none     = (row_low == 4'h0);
    single   = !none && ((row_low & (row_low - 4'd1)) == 4'h0);
    row_idx  = onehot_index(row_low);
    col_idx  = onehot_index(~col_choice);
    col_next = {col_choice[2:0], col_choice[3]};
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_choice;
    match_d = match_q;
    rel_d   = rel_q;
    cand_d  = cand_q;
    code_d  = key_code;
    valid_d = 1'b0;
    held_d  = key_held;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (single) begin
            cand_d  = {row_idx, col_idx};
            match_d = CNT_W'(1);
            state_d = DEBOUNCE;
          end else begin
            col_d = col_next;
          end
        end
        DEBOUNCE: begin
          if (single && (row_idx == cand_q[3:2])) begin
            if (match_q == CNT_LAST) begin
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              rel_d   = '0;
              state_d = HELD;
            end else begin
              match_d = match_q + CNT_W'(1);
            end
          end else begin
            state_d = SCAN;
            col_d   = col_next;
          end
        end
        HELD: begin
          // Any non-idle sample restarts the release count; other columns are never looked at
          if (none) begin
            if (rel_q == CNT_LAST) begin
              held_d  = 1'b0;
              rel_d   = '0;
              state_d = SCAN;
              col_d   = col_next;
            end else begin
              rel_d = rel_q + CNT_W'(1);
            end
          end else begin
            rel_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SCAN;
      col_choice <= 4'b1110;
      match_q    <= '0;
      rel_q      <= '0;
      cand_q     <= 4'h0;
      key_code   <= 4'h0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_choice <= col_d;
      match_q    <= match_d;
      rel_q      <= rel_d;
      cand_q     <= cand_d;
      key_code   <= code_d;
      key_valid  <= valid_d;
      key_held   <= held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a 16-key matrix model drives the rows from the
// column drive, and a tick-level behavioural scanner predicts the outputs.
module tb_keypad_scanner;

  localparam int CLK_DIV = 4;
  localparam int DS      = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row;
  logic [3:0] col_choice;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed = 16'h0;

  int n_checks = 0;
  int n_pass   = 0;
  int valid_seen = 0;

  // behavioural scanner state (0 scanning, 1 confirming, 2 held)
  int m_state, m_col, m_cand, m_streak, m_rel, m_code;
  bit m_held;

  keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk),
    .reset(reset),
    .row(row),
    .col_choice(col_choice),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_choice[c]) row[r] = 1'b0;
  end

  function automatic logic [3:0] model_rows(input int c);
    logic [3:0] s;
    s = 4'hF;
    for (int r = 0; r < 4; r++)
      if (pressed[r*4+c]) s[r] = 1'b0;
    return s;
  endfunction

  function automatic logic [3:0] col_pattern(input int c);
    logic [3:0] p;
    p = 4'hF;
    p[c] = 1'b0;
    return p;
  endfunction

  task automatic model_reset();
    m_state = 0; m_col = 0; m_cand = 0; m_streak = 0; m_rel = 0; m_code = 0; m_held = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One scan period: the model digests the sample its current column sees,
  // then the DUT is compared just after the tick edge.
  task automatic do_tick();
    logic [3:0] s;
    int nlow, r;
    bit exp_v;
    logic [3:0] exp_code;
    s = model_rows(m_col);
    nlow = 0; r = 0;
    for (int i = 0; i < 4; i++) if (!s[i]) begin nlow++; r = i; end
    exp_v = 1'b0;
    case (m_state)
      0: if (nlow == 1) begin m_cand = r*4 + m_col; m_streak = 1; m_state = 1; end
         else m_col = (m_col + 1) % 4;
      1: if (nlow == 1 && r == m_cand / 4) begin
           m_streak++;
           if (m_streak == DS) begin
             m_code = m_cand; m_held = 1; exp_v = 1; m_rel = 0; m_state = 2;
           end
         end else begin
           m_state = 0; m_col = (m_col + 1) % 4;
         end
      default: if (nlow == 0) begin
           m_rel++;
           if (m_rel == DS) begin m_held = 0; m_state = 0; m_col = (m_col + 1) % 4; end
         end else m_rel = 0;
    endcase
    for (int i = 0; i < CLK_DIV; i++) begin
      @(posedge clk); #1;
      if (key_valid === 1'b1) valid_seen++;
      if (i < CLK_DIV - 1) begin
        n_checks++;
        if (key_valid !== 1'b0) $display("FAIL idle_valid: got %b want 0 at %0t", key_valid, $time);
        else n_pass++;
      end
    end
    exp_code = m_code[3:0];
    n_checks++;
    if (col_choice !== col_pattern(m_col))
      $display("FAIL tick_col: got %b want %b at %0t", col_choice, col_pattern(m_col), $time);
    else n_pass++;
    n_checks++;
    if (key_valid !== exp_v) $display("FAIL tick_valid: got %b want %b at %0t", key_valid, exp_v, $time);
    else n_pass++;
    n_checks++;
    if (key_code !== exp_code) $display("FAIL tick_code: got %0d want %0d at %0t", key_code, exp_code, $time);
    else n_pass++;
    n_checks++;
    if (key_held !== m_held) $display("FAIL tick_held: got %b want %b at %0t", key_held, m_held, $time);
    else n_pass++;
  endtask

  task automatic wait_col(input int c);
    for (int k = 0; k < 8 && m_col != c; k++) do_tick();
    n_checks++;
    if (col_choice !== col_pattern(c)) $display("FAIL wait_col: got %b want %b", col_choice, col_pattern(c));
    else n_pass++;
  endtask

  task automatic test_reset();
    pressed = 16'h0;
    repeat (2) @(negedge clk);
    release_reset();
    do_tick();
    do_tick();
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if (col_choice !== 4'b1110) $display("FAIL rst_col: got %b want 1110", col_choice); else n_pass++;
    n_checks++;
    if (key_code !== 4'h0) $display("FAIL rst_code: got %0d want 0", key_code); else n_pass++;
    n_checks++;
    if (key_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", key_valid); else n_pass++;
    n_checks++;
    if (key_held !== 1'b0) $display("FAIL rst_held: got %b want 0", key_held); else n_pass++;
    release_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (col_choice !== ((i < 3) ? 4'b1110 : 4'b1101))
        $display("FAIL rst_first_step: cycle %0d got %b want %b", i + 1, col_choice, (i < 3) ? 4'b1110 : 4'b1101);
      else n_pass++;
    end
    m_col = 1;
  endtask

  task automatic test_clean_press();
    valid_seen = 0;
    pressed = 16'h0;
    pressed[9] = 1'b1;
    repeat (8) do_tick();
    n_checks++;
    if (valid_seen != 1) $display("FAIL press_pulses: got %0d want 1", valid_seen); else n_pass++;
    n_checks++;
    if (key_code !== 4'd9) $display("FAIL press_code: got %0d want 9", key_code); else n_pass++;
    n_checks++;
    if (key_held !== 1'b1) $display("FAIL press_held: got %b want 1", key_held); else n_pass++;
    n_checks++;
    if (col_choice !== 4'b1101) $display("FAIL press_col: got %b want 1101", col_choice); else n_pass++;
    pressed = 16'h0;
    repeat (4) do_tick();
    n_checks++;
    if (key_held !== 1'b0) $display("FAIL press_release: got %b want 0", key_held); else n_pass++;
  endtask

  task automatic test_bounce();
    wait_col(1);
    valid_seen = 0;
    pressed[5] = 1'b1;
    do_tick();
    pressed = 16'h0;
    do_tick();
    n_checks++;
    if (valid_seen != 0) $display("FAIL bounce_pulses: got %0d want 0", valid_seen); else n_pass++;
    n_checks++;
    if (key_code !== 4'd9) $display("FAIL bounce_code: got %0d want 9", key_code); else n_pass++;
    n_checks++;
    if (col_choice !== 4'b1011) $display("FAIL bounce_col: got %b want 1011", col_choice); else n_pass++;
  endtask

  task automatic test_multi();
    wait_col(2);
    valid_seen = 0;
    pressed[2]  = 1'b1;
    pressed[14] = 1'b1;
    do_tick();
    n_checks++;
    if (col_choice !== 4'b0111) $display("FAIL multi_col: got %b want 0111", col_choice); else n_pass++;
    repeat (8) do_tick();
    n_checks++;
    if (valid_seen != 0) $display("FAIL multi_pulses: got %0d want 0", valid_seen); else n_pass++;
    n_checks++;
    if (key_held !== 1'b0) $display("FAIL multi_held: got %b want 0", key_held); else n_pass++;
    pressed = 16'h0;
  endtask

  task automatic test_long_hold();
    valid_seen = 0;
    pressed[15] = 1'b1;
    repeat (8) do_tick();
    n_checks++;
    if (key_code !== 4'd15) $display("FAIL hold_code: got %0d want 15", key_code); else n_pass++;
    repeat (45) do_tick();
    pressed = 16'h0;
    do_tick();
    pressed[15] = 1'b1;
    repeat (46) do_tick();
    n_checks++;
    if (key_held !== 1'b1) $display("FAIL hold_glitch: got %b want 1", key_held); else n_pass++;
    n_checks++;
    if (valid_seen != 1) $display("FAIL hold_pulses: got %0d want 1", valid_seen); else n_pass++;
    n_checks++;
    if (col_choice !== 4'b0111) $display("FAIL hold_col: got %b want 0111", col_choice); else n_pass++;
    pressed = 16'h0;
    repeat (2) do_tick();
    n_checks++;
    if (key_held !== 1'b1) $display("FAIL hold_early_release: got %b want 1", key_held); else n_pass++;
    do_tick();
    n_checks++;
    if (key_held !== 1'b0) $display("FAIL hold_release: got %b want 0", key_held); else n_pass++;
    n_checks++;
    if (col_choice !== 4'b1110) $display("FAIL hold_release_col: got %b want 1110", col_choice); else n_pass++;
  endtask

  task automatic test_reset_debounce();
    valid_seen = 0;
    pressed = 16'h0;
    pressed[4 + m_col] = 1'b1;
    repeat (2) do_tick();
    @(posedge clk); #3;
    reset = 1'b1;
    pressed = 16'h0;
    #1;
    n_checks++;
    if (col_choice !== 4'b1110) $display("FAIL deb_rst_col: got %b want 1110", col_choice); else n_pass++;
    n_checks++;
    if (key_code !== 4'h0) $display("FAIL deb_rst_code: got %0d want 0", key_code); else n_pass++;
    release_reset();
    repeat (6) do_tick();
    n_checks++;
    if (valid_seen != 0) $display("FAIL deb_rst_pulses: got %0d want 0", valid_seen); else n_pass++;
    n_checks++;
    if (key_held !== 1'b0) $display("FAIL deb_rst_held: got %b want 0", key_held); else n_pass++;
  endtask

  task automatic test_random();
    int sel;
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 1) pressed = 16'h0;
      else if (sel == 2) pressed[$urandom_range(0, 15)] = 1'b1;
      else if (sel == 3) begin
        pressed = 16'h0;
        pressed[$urandom_range(0, 15)] = 1'b1;
      end
      do_tick();
    end
    pressed = 16'h0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi();
    test_long_hold();
    test_reset_debounce();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix keypad reader for the calculator: the input-side counterpart of the multiplexed display driver. It drives one active-low keypad column at a time (as the display drives one digit select at a time), samples the four row lines, debounces a single pressed key, and reports it as a 4-bit code with a one-cycle strobe. The core logic consumes its outputs the same way the display path consumes values to draw.

## Interface
- CLK_DIV, default 1000: clock cycles each column is driven before sampling and advancing; must be ≥ 4.
- DEBOUNCE_SCANS, default 4: consecutive identical samples needed to accept a press or a release; must be ≥ 2.

- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- row  in  4  keypad rows, active-low (pulled up); asynchronous to clk.
- col_choice  out  4  column drive, one-hot active-low; exactly one bit is low at all times.
- key_code  out  4  code of the last accepted key: row_index*4 + col_index.
- key_valid  out  1  one-cycle pulse when a key is accepted.
- key_held  out  1  high from acceptance until the release is debounced.

## Operation
- Input path: row passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Divider: counts 0..CLK_DIV-1 and wraps; `tick` is the cycle where the count equals CLK_DIV-1. Sampling happens only on ticks.
- Column sequence (col_choice): 1110 → 1101 → 1011 → 0111 → 1110, wrapping. col_index is the position of the low bit (0..3).
- Sample classification on a tick: NONE if all rows are high; SINGLE(r) if exactly one row r is low; MULTI if two or more rows are low.
- State SCAN:
  - On a tick with NONE or MULTI, advance the column.
  - On a tick with SINGLE(r), latch candidate = r*4 + col_index, set the match count to 1, and go to DEBOUNCE. The column does not advance.
- State DEBOUNCE (column frozen):
  - On a tick with SINGLE of the same row, increment the match count.
  - When the count reaches DEBOUNCE_SCANS, on the next cycle load key_code with the candidate, pulse key_valid, set key_held, and go to HELD.
  - On any other sample, return to SCAN and advance the column. There is no output.
- State HELD (column frozen):
  - On a tick with NONE, increment the release count. On any other sample, clear the release count.
  - When the release count reaches DEBOUNCE_SCANS, clear key_held, return to SCAN, and advance the column.
- A held key produces exactly one key_valid. Pressing another key in a different column during HELD has no effect.
- key_code holds its value until the next acceptance. It is never cleared except by reset.
- Reset mid-operation, in any state: the state goes to SCAN, all counters clear, and outputs take their reset values. A debounce in progress is discarded.

## Timing
- Reset values: col_choice = 4'b1110, key_code = 4'h0, key_valid = 0, key_held = 0, state SCAN, divider 0.
- Row-to-logic latency is 2 cycles. Because CLK_DIV ≥ 4, the rows have settled after a column change before the next tick.
- col_choice changes in the cycle after an advancing tick and is registered, so it is glitch-free.
- Press latency, counting from the first tick that sees SINGLE: DEBOUNCE_SCANS-1 further ticks, then key_valid is high in the cycle after the final matching tick.
- key_code and key_held update in the same cycle that key_valid is high.
- key_held falls in the cycle after the tick that completes the release count. col_choice advances in that same cycle.

## Test plan
- Reset: assert reset asynchronously between clock edges. Outputs go to 1110/0/0/0 without waiting for an edge. After release, col_choice steps 1110→1101 after 4 cycles (CLK_DIV=4).
- Clean press, CLK_DIV=4, DEBOUNCE_SCANS=3: hold row[2] low while col_choice=1101. Expect key_code=9, a single one-cycle key_valid on the cycle after the 3rd matching tick, key_held=1, and col_choice frozen at 1101.
- Bounce: row[1] low for exactly one tick, then high. Expect no key_valid, key_code unchanged, and scanning resuming at the next column.
- Multi-key: row[0] and row[3] both low in column 2. Expect MULTI to be ignored, no key_valid, and col_choice continuing to advance.
- Long hold and release: key 15 (row 3, col 3) held for 100 ticks. Expect exactly one key_valid. After rows are high for 3 ticks, key_held=0 and col_choice goes 0111→1110. A 1-tick release glitch mid-hold must not end HELD.
- Reset in DEBOUNCE: reset after 2 matching ticks. Expect no key_valid, state SCAN, and col_choice=1110.
